btb_update_queue: RTL and testbench

- Write-side producer for the BTB update port.
- Accepts resolved/committed BTB training requests from the backend commit path. Buffers them in a small in-order FIFO and presents one update per cycle to the BTB's single write port (update / start_addr / btbEntry).
- Optionally coalesces repeated updates to the same fetch-block start address, so a hot branch does not flood the port.

---
 rtl/btb_update_queue.sv | 113 +++++++++++
 tb/tb_btb_update_queue.sv | 181 ++++++++++++++++++
 2 files changed

// File: rtl/btb_update_queue.sv
// In-order update queue feeding the BTB's single write port.
// Define BTB_UPD_MERGE_EN to coalesce queued updates that share a start address.
module btb_update_queue #(
  parameter int VADDR_W = 39,
  parameter int ENTRY_W = 64,
  parameter int DEPTH   = 4
) (
  input  logic                     clk,
  input  logic                     rst,
  input  logic                     enq_valid,
  output logic                     enq_ready,
  input  logic [VADDR_W-1:0]       enq_start_addr,
  input  logic [ENTRY_W-1:0]       enq_entry,
  output logic                     upd_valid,
  input  logic                     upd_ready,
  output logic [VADDR_W-1:0]       upd_start_addr,
  output logic [ENTRY_W-1:0]       upd_entry,
  output logic [$clog2(DEPTH):0]   count
);

  localparam int PW = $clog2(DEPTH);
  localparam logic [PW:0] PTR_ONE = {{PW{1'b0}}, 1'b1};

  logic [PW:0]          head_q, head_d, tail_q, tail_d;
  logic [DEPTH-1:0]     vld_q, vld_d;
  logic [VADDR_W-1:0]   addr_q  [DEPTH];
  logic [VADDR_W-1:0]   addr_d  [DEPTH];
  logic [ENTRY_W-1:0]   entry_q [DEPTH];
  logic [ENTRY_W-1:0]   entry_d [DEPTH];

  logic [PW-1:0] head_idx, tail_idx;
  logic          full, empty;
  logic          enq_fire, deq_fire, merge_hit, store;

  assign head_idx = head_q[PW-1:0];
  assign tail_idx = tail_q[PW-1:0];
  assign empty    = (head_q == tail_q);
  assign full     = (head_q[PW] != tail_q[PW]) && (head_idx == tail_idx);
  assign count    = tail_q - head_q;

  assign enq_ready      = ~full;
  assign upd_valid      = ~empty;
  assign upd_start_addr = empty ? '0 : addr_q[head_idx];
  assign upd_entry      = empty ? '0 : entry_q[head_idx];

  assign enq_fire = enq_valid & enq_ready;
  assign deq_fire = upd_valid & upd_ready;

`ifdef BTB_UPD_MERGE_EN
  logic [DEPTH-1:0] match;
  logic [PW-1:0]    merge_idx;

  // A head leaving this cycle is not a merge target; the request appends instead.
  for (genvar gi = 0; gi < DEPTH; gi++) begin : g_match
    assign match[gi] = vld_q[gi] && (addr_q[gi] == enq_start_addr) &&
                       !(deq_fire && (head_idx == PW'(gi)));
  end

  always_comb begin
    merge_idx = '0;
    for (int i = 0; i < DEPTH; i++) begin
      if (match[i]) merge_idx = PW'(i);
    end
  end

  assign merge_hit = enq_fire & enq_entry[0] & (|match);
`else
  assign merge_hit = 1'b0;
`endif

  assign store = enq_fire & enq_entry[0] & ~merge_hit;

  always_comb begin
    head_d  = head_q;
    tail_d  = tail_q;
    vld_d   = vld_q;
    addr_d  = addr_q;
    entry_d = entry_q;
    if (deq_fire) begin
      vld_d[head_idx] = 1'b0;
      head_d          = head_q + PTR_ONE;
    end
    // Store and dequeue never share a slot: that needs empty or full.
    if (store) begin
      vld_d[tail_idx]   = 1'b1;
      addr_d[tail_idx]  = enq_start_addr;
      entry_d[tail_idx] = enq_entry;
      tail_d            = tail_q + PTR_ONE;
    end
`ifdef BTB_UPD_MERGE_EN
    if (merge_hit) entry_d[merge_idx] = enq_entry;
`endif
  end

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      head_q <= '0;
      tail_q <= '0;
      vld_q  <= '0;
      for (int i = 0; i < DEPTH; i++) begin
        addr_q[i]  <= '0;
        entry_q[i] <= '0;
      end
    end else begin
      head_q  <= head_d;
      tail_q  <= tail_d;
      vld_q   <= vld_d;
      addr_q  <= addr_d;
      entry_q <= entry_d;
    end
  end

endmodule

// File: tb/tb_btb_update_queue.sv
// Scoreboard bench for btb_update_queue: directed scenarios plus random traffic
// checked every cycle against a queue-based reference model.
module tb_btb_update_queue;
  localparam int VADDR_W = 39;
  localparam int ENTRY_W = 64;
  localparam int DEPTH   = 4;

  logic                   clk = 1'b0;
  logic                   rst;
  logic                   enq_valid, enq_ready, upd_valid, upd_ready;
  logic [VADDR_W-1:0]     enq_start_addr, upd_start_addr;
  logic [ENTRY_W-1:0]     enq_entry, upd_entry;
  logic [$clog2(DEPTH):0] count;

  btb_update_queue #(.VADDR_W(VADDR_W), .ENTRY_W(ENTRY_W), .DEPTH(DEPTH)) dut (
    .clk(clk), .rst(rst),
    .enq_valid(enq_valid), .enq_ready(enq_ready),
    .enq_start_addr(enq_start_addr), .enq_entry(enq_entry),
    .upd_valid(upd_valid), .upd_ready(upd_ready),
    .upd_start_addr(upd_start_addr), .upd_entry(upd_entry),
    .count(count)
  );

  always #5 clk = ~clk;

  typedef struct packed {
    logic [VADDR_W-1:0] a;
    logic [ENTRY_W-1:0] e;
  } item_t;

  item_t model_q[$];
  int    n_checks = 0;
  int    n_fail   = 0;
`ifdef BTB_UPD_MERGE_EN
  localparam bit MERGE = 1'b1;
`else
  localparam bit MERGE = 1'b0;
`endif

  task automatic check(input string name, input logic [63:0] act, input logic [63:0] exp);
    n_checks++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s: got %h expected %h at %0t", name, act, exp, $time);
    end
  endtask

  // Monitor: compare outputs on negedge, advance the model on posedge.
  initial begin
    forever begin
      @(negedge clk);
      if (rst === 1'b1) begin
        check("count", 64'(count), 64'(model_q.size()));
        check("enq_ready", 64'(enq_ready), 64'(model_q.size() < DEPTH));
        check("upd_valid", 64'(upd_valid), 64'(model_q.size() != 0));
        if (model_q.size() != 0) begin
          check("upd_addr", 64'(upd_start_addr), 64'(model_q[0].a));
          check("upd_entry", upd_entry, model_q[0].e);
        end else begin
          check("idle_addr", 64'(upd_start_addr), 64'd0);
          check("idle_entry", upd_entry, 64'd0);
        end
      end
      @(posedge clk);
      if (rst === 1'b1) begin
        bit acc, deq, hit;
        acc = enq_valid && (model_q.size() < DEPTH);
        deq = upd_ready && (model_q.size() != 0);
        if (deq) void'(model_q.pop_front());
        if (acc && enq_entry[0]) begin
          hit = 1'b0;
          if (MERGE) begin
            foreach (model_q[k]) begin
              if (model_q[k].a == enq_start_addr) begin
                model_q[k].e = enq_entry;
                hit = 1'b1;
              end
            end
          end
          if (!hit) model_q.push_back('{a: enq_start_addr, e: enq_entry});
        end
      end
    end
  end

  task automatic cyc(input logic v, input logic [VADDR_W-1:0] a,
                     input logic [ENTRY_W-1:0] e, input logic r);
    @(negedge clk);
    #1;
    enq_valid = v; enq_start_addr = a; enq_entry = e; upd_ready = r;
  endtask

  initial begin
    bit done;
    rst = 1'b0; enq_valid = 0; enq_start_addr = '0; enq_entry = '0; upd_ready = 0;
    repeat (2) @(negedge clk);
    check("rst_valid", 64'(upd_valid), 64'd0);
    check("rst_ready", 64'(enq_ready), 64'd1);
    check("rst_count", 64'(count), 64'd0);
    #1 rst = 1'b1;

    // Single pass
    cyc(1, 39'h1000, 64'h0000_0000_0000_0001, 1);
    cyc(0, '0, '0, 1);
    check("single_valid", 64'(upd_valid), 64'd1);
    check("single_addr", 64'(upd_start_addr), 64'h1000);
    cyc(0, '0, '0, 1);
    check("single_drain", 64'(count), 64'd0);

    // Full and backpressure
    cyc(1, 39'h10, 64'h11, 0);
    cyc(1, 39'h20, 64'h21, 0);
    cyc(1, 39'h30, 64'h31, 0);
    cyc(1, 39'h40, 64'h41, 0);
    cyc(1, 39'h50, 64'h51, 0);
    check("full_count", 64'(count), 64'd4);
    check("full_ready", 64'(enq_ready), 64'd0);
    cyc(1, 39'h50, 64'h51, 0);
    done = 1'b0;
    for (int i = 0; i < 10 && !done; i++) begin
      cyc(1, 39'h50, 64'h51, 1);
      if (enq_ready) done = 1'b1;
    end
    check("fifth_accepted", 64'(done), 64'd1);
    repeat (6) cyc(0, '0, '0, 1);

    // en=0 drop
    cyc(1, 39'h77, 64'h7770, 1);
    check("drop_ready", 64'(enq_ready), 64'd1);
    cyc(0, '0, '0, 1);
    check("drop_count", 64'(count), 64'd0);
    check("drop_valid", 64'(upd_valid), 64'd0);

    // Merge
    cyc(1, 39'h100, 64'hA1, 0);
    cyc(1, 39'h200, 64'hB1, 0);
    cyc(1, 39'h100, 64'hC1, 0);
    cyc(0, '0, '0, 0);
    check("merge_count", 64'(count), MERGE ? 64'd2 : 64'd3);
    check("merge_head", upd_entry, MERGE ? 64'hC1 : 64'hA1);
    repeat (5) cyc(0, '0, '0, 1);

    // Departing head
    cyc(1, 39'h100, 64'hE1, 1);
    cyc(1, 39'h100, 64'hD1, 1);
    check("depart_head", upd_entry, 64'hE1);
    cyc(0, '0, '0, 0);
    check("depart_count", 64'(count), 64'd1);
    check("depart_entry", upd_entry, 64'hD1);
    cyc(0, '0, '0, 1);

    // Async reset mid-operation
    cyc(1, 39'h10, 64'h11, 0);
    cyc(1, 39'h20, 64'h21, 0);
    cyc(1, 39'h30, 64'h31, 0);
    cyc(0, '0, '0, 0);
    #2 rst = 1'b0;
    #1;
    check("arst_valid", 64'(upd_valid), 64'd0);
    check("arst_count", 64'(count), 64'd0);
    check("arst_ready", 64'(enq_ready), 64'd1);
    check("arst_addr", 64'(upd_start_addr), 64'd0);
    model_q.delete();
    @(negedge clk);
    #1 rst = 1'b1;

    // Random traffic over a small address set to provoke merges
    for (int i = 0; i < 2000; i++) begin
      logic [ENTRY_W-1:0] e;
      e = {$urandom, $urandom};
      e[0] = ($urandom_range(0, 3) != 0);
      cyc($urandom_range(0, 9) < 7, VADDR_W'($urandom_range(1, 5) << 4), e,
          $urandom_range(0, 9) < 6);
    end
    repeat (8) cyc(0, '0, '0, 1);
    check("final_count", 64'(count), 64'd0);

    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end
endmodule
